// File: rtl/ps2_if.sv
// Output bundle of the PS/2 receiver: received byte, its strobe and the held debug byte.
// The receiver drives the master side; downstream logic observes through the slave side.
interface ps2_if;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;

  modport master (output ps2_key_data, output ps2_key_pressed, output ps2_out);
  modport slave  (input  ps2_key_data, input  ps2_key_pressed, input  ps2_out);
endinterface

// File: rtl/ps2_interface.sv
// Receive-only PS/2 keyboard port: synchronises and de-glitches the PS/2 lines,
// deframes 11-bit frames and reports each valid byte with a one-cycle strobe.
module ps2_interface #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic   clock,
  input  logic   reset,
  inout  wire    ps2_clock,
  inout  wire    ps2_data,
  ps2_if.master  bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Odd parity holds when the data bits plus the parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic          filt_clk_r;
  logic          filt_prev_r;
  logic [FW-1:0] filt_cnt_r;
  logic          sample_en_s;
  logic          data_bit_s;

  state_t        state_r, state_n;
  logic [3:0]    bit_cnt_r, bit_cnt_n;
  logic [9:0]    shift_r, shift_n;
  logic [TW-1:0] tmo_r, tmo_n;
  logic [7:0]    key_data_r, key_data_n;
  logic          pressed_r, pressed_n;
  logic [7:0]    out_r, out_n;

  // The PS/2 lines are only ever sampled; this port never pulls them low.

  // Two-flop synchronisers for both PS/2 lines (idle level is high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clock};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Glitch filter: the filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_clk_r  <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= '0;
    end else begin
      filt_prev_r <= filt_clk_r;
      if (clk_sync_r[1] == filt_clk_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FILT_LAST) begin
        filt_clk_r <= clk_sync_r[1];
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  assign sample_en_s = filt_prev_r & ~filt_clk_r;
  assign data_bit_s  = data_sync_r[1];

  // Frame state and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 10'd0;
      tmo_r      <= '0;
      key_data_r <= 8'd0;
      pressed_r  <= 1'b0;
      out_r      <= 8'd0;
    end else begin
      state_r    <= state_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      tmo_r      <= tmo_n;
      key_data_r <= key_data_n;
      pressed_r  <= pressed_n;
      out_r      <= out_n;
    end
  end

  // Deframer: shift register holds D0..D7, parity, stop once ten bits follow the start bit.
  always_comb begin
    state_n    = state_r;
    bit_cnt_n  = bit_cnt_r;
    shift_n    = shift_r;
    tmo_n      = tmo_r;
    key_data_n = key_data_r;
    pressed_n  = 1'b0;
    out_n      = out_r;
    case (state_r)
      IDLE: begin
        tmo_n = '0;
        if (sample_en_s && (data_bit_s == 1'b0)) begin
          state_n   = RECV;
          bit_cnt_n = 4'd0;
          shift_n   = 10'd0;
        end else begin
          state_n = IDLE;
        end
      end
      RECV: begin
        if (sample_en_s) begin
          shift_n = {data_bit_s, shift_r[9:1]};
          tmo_n   = '0;
          if (bit_cnt_r == 4'd9) begin
            state_n   = CHECK;
            bit_cnt_n = 4'd0;
          end else begin
            bit_cnt_n = bit_cnt_r + 4'd1;
          end
        end else if (tmo_r == TMO_LAST) begin
          // Stalled mid-frame: abandon the partial frame.
          state_n   = IDLE;
          bit_cnt_n = 4'd0;
          shift_n   = 10'd0;
          tmo_n     = '0;
        end else begin
          tmo_n = tmo_r + TW'(1);
        end
      end
      CHECK: begin
        if (odd_parity_ok(shift_r[7:0], shift_r[8]) && shift_r[9]) begin
          key_data_n = shift_r[7:0];
          out_n      = shift_r[7:0];
          pressed_n  = 1'b1;
        end else begin
          pressed_n = 1'b0;
        end
        state_n   = IDLE;
        bit_cnt_n = 4'd0;
        shift_n   = 10'd0;
        tmo_n     = '0;
      end
      default: begin
        state_n   = IDLE;
        bit_cnt_n = 4'd0;
        shift_n   = 10'd0;
        tmo_n     = '0;
      end
    endcase
  end

  assign bus.ps2_key_data    = key_data_r;
  assign bus.ps2_key_pressed = pressed_r;
  assign bus.ps2_out         = out_r;

endmodule

// File: tb/tb_ps2_interface.sv
// Directed bench for ps2_interface: valid, erroneous, timed-out, glitched and reset-interrupted frames.
module tb_ps2_interface;
  localparam int TMO = 2000;

  logic clock;
  logic reset;
  logic ps2_clk_drv;
  logic ps2_dat_drv;
  wire  ps2_clock_w;
  wire  ps2_data_w;

  int errors;
  int checks;
  int strobe_cnt;
  int double_cnt;
  int base;
  logic prev_pressed;

  assign ps2_clock_w = ps2_clk_drv;
  assign ps2_data_w  = ps2_dat_drv;

  ps2_if bus ();

  ps2_interface #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clock (ps2_clock_w),
    .ps2_data  (ps2_data_w),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count strobes and flag any strobe lasting two clocks.
  always @(negedge clock) begin
    if (bus.ps2_key_pressed === 1'b1) strobe_cnt = strobe_cnt + 1;
    if (prev_pressed === 1'b1 && bus.ps2_key_pressed === 1'b1) double_cnt = double_cnt + 1;
    prev_pressed = bus.ps2_key_pressed;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One PS/2 bit: data set while clock high, then an 80-clock bit period.
  task automatic send_bit(input logic v, input logic glitch);
    ps2_dat_drv = v;
    wait_clks(10);
    if (glitch) begin
      ps2_clk_drv = 1'b0;
      wait_clks(1);
      ps2_clk_drv = 1'b1;
      wait_clks(9);
    end else begin
      wait_clks(10);
    end
    ps2_clk_drv = 1'b0;
    wait_clks(40);
    ps2_clk_drv = 1'b1;
    wait_clks(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int glitch_bit);
    send_bit(1'b0, glitch_bit == 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i + 1);
    send_bit(par, glitch_bit == 9);
    send_bit(stp, glitch_bit == 10);
    ps2_dat_drv = 1'b1;
  endtask

  task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ps2_clk_drv = 1'b1;
    ps2_dat_drv = 1'b1;
    wait_clks(5);
    check_byte("reset_key_data", bus.ps2_key_data, 8'h00);
    check_byte("reset_out", bus.ps2_out, 8'h00);
    checks = checks + 1;
    if (bus.ps2_key_pressed !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_pressed: got %b expected 0", bus.ps2_key_pressed);
    end
    reset = 1'b0;
    wait_clks(200);
    check_byte("idle_key_data", bus.ps2_key_data, 8'h00);
    check_byte("idle_out", bus.ps2_out, 8'h00);
    checks = checks + 1;
    if (strobe_cnt !== 0) begin
      errors = errors + 1;
      $display("FAIL idle_strobes: got %0d expected 0", strobe_cnt);
    end
  endtask

  task automatic test_single;
    base = strobe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    checks = checks + 1;
    if (strobe_cnt - base !== 1) begin
      errors = errors + 1;
      $display("FAIL single_strobes: got %0d expected 1", strobe_cnt - base);
    end
    check_byte("single_key_data", bus.ps2_key_data, 8'h1C);
    check_byte("single_out", bus.ps2_out, 8'h1C);
  endtask

  task automatic test_back_to_back;
    base = strobe_cnt;
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    check_byte("b2b_first_out", bus.ps2_out, 8'hF0);
    check_byte("b2b_first_key", bus.ps2_key_data, 8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    checks = checks + 1;
    if (strobe_cnt - base !== 2) begin
      errors = errors + 1;
      $display("FAIL b2b_strobes: got %0d expected 2", strobe_cnt - base);
    end
    check_byte("b2b_second_out", bus.ps2_out, 8'h1C);
    check_byte("b2b_second_key", bus.ps2_key_data, 8'h1C);
  endtask

  task automatic test_errors;
    base = strobe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    checks = checks + 1;
    if (strobe_cnt - base !== 0) begin
      errors = errors + 1;
      $display("FAIL parity_err_strobes: got %0d expected 0", strobe_cnt - base);
    end
    check_byte("parity_err_out", bus.ps2_out, 8'h1C);
    wait_clks(100);
    send_frame(8'hF0, 1'b1, 1'b0, -1);
    checks = checks + 1;
    if (strobe_cnt - base !== 0) begin
      errors = errors + 1;
      $display("FAIL stop_err_strobes: got %0d expected 0", strobe_cnt - base);
    end
    check_byte("stop_err_out", bus.ps2_out, 8'h1C);
    wait_clks(100);
  endtask

  task automatic test_timeout;
    base = strobe_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    ps2_dat_drv = 1'b1;
    wait_clks(TMO + 500);
    send_frame(8'h29, 1'b0, 1'b1, -1);
    checks = checks + 1;
    if (strobe_cnt - base !== 1) begin
      errors = errors + 1;
      $display("FAIL timeout_strobes: got %0d expected 1", strobe_cnt - base);
    end
    check_byte("timeout_out", bus.ps2_out, 8'h29);
    check_byte("timeout_key", bus.ps2_key_data, 8'h29);
  endtask

  task automatic test_glitch;
    base = strobe_cnt;
    for (int i = 0; i < 3; i++) begin
      ps2_clk_drv = 1'b0;
      wait_clks(1);
      ps2_clk_drv = 1'b1;
      wait_clks(30);
    end
    checks = checks + 1;
    if (strobe_cnt - base !== 0) begin
      errors = errors + 1;
      $display("FAIL glitch_idle_strobes: got %0d expected 0", strobe_cnt - base);
    end
    send_frame(8'hF0, 1'b1, 1'b1, 4);
    checks = checks + 1;
    if (strobe_cnt - base !== 1) begin
      errors = errors + 1;
      $display("FAIL glitch_frame_strobes: got %0d expected 1", strobe_cnt - base);
    end
    check_byte("glitch_frame_out", bus.ps2_out, 8'hF0);
  endtask

  task automatic test_reset_mid_frame;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    reset = 1'b1;
    wait_clks(3);
    check_byte("midreset_out", bus.ps2_out, 8'h00);
    check_byte("midreset_key", bus.ps2_key_data, 8'h00);
    ps2_dat_drv = 1'b1;
    reset = 1'b0;
    wait_clks(50);
    base = strobe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    checks = checks + 1;
    if (strobe_cnt - base !== 1) begin
      errors = errors + 1;
      $display("FAIL midreset_strobes: got %0d expected 1", strobe_cnt - base);
    end
    check_byte("midreset_next_out", bus.ps2_out, 8'h1C);
    check_byte("midreset_next_key", bus.ps2_key_data, 8'h1C);
    checks = checks + 1;
    if (double_cnt !== 0) begin
      errors = errors + 1;
      $display("FAIL strobe_width: got %0d double strobes expected 0", double_cnt);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    strobe_cnt = 0;
    double_cnt = 0;
    base = 0;
    prev_pressed = 1'b0;
    reset = 1'b1;
    ps2_clk_drv = 1'b1;
    ps2_dat_drv = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
